// File: rtl/prbs31_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions for the pattern generator and checker.
package prbs31_pkg;

    localparam int PRBS31_W     = 31;
    localparam int PRBS31_TAP_A = 27;
    localparam int PRBS31_TAP_B = 30;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs31_state_e;

    // s[0] is the newest bit; the result is the bit that follows s.
    function automatic logic prbs31_next(input logic [PRBS31_W-1:0] s);
        return s[PRBS31_TAP_A] ^ s[PRBS31_TAP_B];
    endfunction

endpackage

// File: rtl/prbs31_win_mon.sv
// Window error monitor: counts errors per WINDOW-bit block while locked and
// raises unlock_o on the bit that brings the block's error count to UNLOCK_ERRS.
module prbs31_win_mon #(
    parameter int UNLOCK_ERRS = 8,
    parameter int WINDOW      = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic adv_i,
    input  logic err_i,
    output logic unlock_o
);

    localparam int            WW        = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [7:0]    ERR_LIMIT = 8'(UNLOCK_ERRS);

    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [7:0]    win_err_q, win_err_d;
    logic [7:0]    err_sum;

    // win_err_q stays below ERR_LIMIT, so the 8-bit sum cannot overflow.
    always_comb begin
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        unlock_o  = 1'b0;
        err_sum   = win_err_q + {7'd0, err_i};
        if (adv_i) begin
            if (err_sum == ERR_LIMIT) begin
                unlock_o  = 1'b1;
                win_cnt_d = '0;
                win_err_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + WW'(1);
                win_err_d = (win_cnt_q == WIN_LAST) ? 8'd0 : err_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
        end
    end

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 checker: seeds from the line, verifies, then counts errors.
// Define PRBS31_CHK_ERRCNT_EN to build the saturating err_count / clear logic.
//
// state  | meaning
// SEED   | shifting in 31 line bits to form a candidate (non-zero) seed
// VERIFY | predicting from line history; LOCK_CNT straight matches to lock
// LOCKED | free-running prediction; errors counted, window monitor may unlock
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int LOCK_CNT    = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int WINDOW      = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_bit,
    input  logic        rx_valid,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    localparam logic [4:0] SEED_LAST = 5'(PRBS31_W - 1);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);

    prbs31_state_e         state_q, state_d;
    logic [PRBS31_W-1:0]   s_q, s_d;
    logic [4:0]            seed_cnt_q, seed_cnt_d;
    logic [7:0]            match_cnt_q, match_cnt_d;
    logic                  locked_q;
    logic                  err_pulse_q;
    logic                  pred;
    logic                  mismatch;
    logic                  err_evt;
    logic                  win_adv;
    logic                  unlock;

    assign pred     = prbs31_next(s_q);
    assign mismatch = rx_bit ^ pred;
    assign win_adv  = rx_valid && (state_q == LOCKED);

    prbs31_win_mon #(
        .UNLOCK_ERRS (UNLOCK_ERRS),
        .WINDOW      (WINDOW)
    ) u_win_mon (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv_i    (win_adv),
        .err_i    (mismatch),
        .unlock_o (unlock)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        err_evt     = 1'b0;
        if (rx_valid) begin
            case (state_q)
                SEED: begin
                    s_d = {s_q[PRBS31_W-2:0], rx_bit};
                    if (seed_cnt_q == SEED_LAST) begin
                        seed_cnt_d = '0;
                        if (s_d != '0) begin
                            state_d = VERIFY;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end
                VERIFY: begin
                    s_d = {s_q[PRBS31_W-2:0], rx_bit};
                    if (mismatch) begin
                        state_d     = SEED;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else if (match_cnt_q == LOCK_LAST) begin
                        state_d     = LOCKED;
                        match_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                end
                LOCKED: begin
                    // Feeding back the prediction keeps one line error from spreading.
                    s_d     = {s_q[PRBS31_W-2:0], pred};
                    err_evt = mismatch;
                    if (unlock) begin
                        state_d     = SEED;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SEED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= SEED;
            s_q         <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_evt;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

`ifdef PRBS31_CHK_ERRCNT_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (clear) begin
            err_count_d = '0;
        end else if (err_evt && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign err_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Randomised bench for prbs31_checker against a queue-based behavioural model.
module tb_prbs31_checker;

    localparam int LOCK_CNT    = 64;
    localparam int UNLOCK_ERRS = 8;
    localparam int WINDOW      = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_bit = 1'b0;
    logic        rx_valid = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulse = 0;

    always #5 clk = ~clk;

    prbs31_checker #(
        .LOCK_CNT    (LOCK_CNT),
        .UNLOCK_ERRS (UNLOCK_ERRS),
        .WINDOW      (WINDOW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    // ---------------- behavioural model ----------------
    bit hist[$];          // line/predicted history, index 0 newest
    int m_mode;           // 0 seeding, 1 verifying, 2 locked
    int m_seen, m_match, m_wpos, m_werr, m_cnt;
    bit e_locked, e_pulse;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 31; i++) hist.push_back(1'b0);
        m_mode = 0; m_seen = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_cnt = 0;
        e_locked = 1'b0; e_pulse = 1'b0;
    endfunction

    function automatic void push_hist(input bit x);
        hist.push_front(x);
        void'(hist.pop_back());
    endfunction

    function automatic void model_step(input bit b, input bit v, input bit c);
        bit pred, err, any;
        e_pulse = 1'b0;
        err = 1'b0;
        if (v) begin
            pred = hist[27] ^ hist[30];
            if (m_mode == 0) begin
                push_hist(b);
                m_seen++;
                if (m_seen == 31) begin
                    m_seen = 0;
                    any = 1'b0;
                    for (int i = 0; i < 31; i++) any |= hist[i];
                    if (any) m_mode = 1;
                end
            end else if (m_mode == 1) begin
                push_hist(b);
                if (b == pred) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin m_mode = 2; m_match = 0; end
                end else begin
                    m_mode = 0; m_seen = 0; m_match = 0;
                end
            end else begin
                push_hist(pred);
                err = (b != pred);
                e_pulse = err;
                m_werr += int'(err);
                if (m_werr == UNLOCK_ERRS) begin
                    m_mode = 0; m_seen = 0; m_match = 0; m_wpos = 0; m_werr = 0;
                end else begin
                    m_wpos++;
                    if (m_wpos == WINDOW) begin m_wpos = 0; m_werr = 0; end
                end
            end
        end
        if (c) m_cnt = 0;
        else if (err && m_cnt < 65535) m_cnt++;
        e_locked = (m_mode == 2);
    endfunction

    function automatic int exp_count();
`ifdef PRBS31_CHK_ERRCNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst_n) model_reset();
        else model_step(rx_bit, rx_valid, clear);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("locked", {31'd0, locked}, {31'd0, e_locked});
        check("err_pulse", {31'd0, err_pulse}, {31'd0, e_pulse});
        check("err_count", {16'd0, err_count}, exp_count());
    end

    // ---------------- stimulus ----------------
    logic [30:0] g;

    function automatic logic gen_bit();
        logic b;
        b = g[27] ^ g[30];
        g = {g[29:0], b};
        return b;
    endfunction

    task automatic tick(input logic b, input logic v, input logic c);
        rx_bit = b; rx_valid = v; clear = c;
        @(posedge clk);
        @(negedge clk);
        #1;
        if (err_pulse === 1'b1) n_pulse++;
    endtask

    task automatic send(input logic v, input logic flip, input logic c);
        logic b;
        if (v) b = gen_bit() ^ flip;
        else   b = 1'($urandom);
        tick(b, v, c);
    endtask

    task automatic wait_lock(input string name);
        int  nv;
        bit  got;
        nv = 0; got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            send(1'b1, 1'b0, 1'b0);
            nv++;
            if (locked === 1'b1) got = 1'b1;
        end
        check({name, "_reached"}, {31'd0, got}, 32'd1);
        check({name, "_latency"}, nv, 32'd95);
    endtask

    task automatic restart();
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        g = 31'd1;
    endtask

    initial begin
        int nv, lk, k;
        bit got;
        g = 31'd1;
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        rst_n = 1'b0;

        // clean stream, continuous valid
        wait_lock("lock1");
        check("model_lock1", {31'd0, e_locked}, 32'd1);
        n_pulse = 0;
        for (int i = 0; i < 10000; i++) send(1'b1, 1'b0, 1'b0);
        check("clean_pulses", n_pulse, 32'd0);

        // one inverted bit
        send(1'b1, 1'b1, 1'b0);
        check("flip1_pulse", {31'd0, err_pulse}, 32'd1);
`ifdef PRBS31_CHK_ERRCNT_EN
        check("flip1_count", {16'd0, err_count}, 32'd1);
`else
        check("flip1_count", {16'd0, err_count}, 32'd0);
`endif
        check("flip1_locked", {31'd0, locked}, 32'd1);
        n_pulse = 0;
        for (int i = 0; i < 1000; i++) send(1'b1, 1'b0, 1'b0);
        check("flip1_after", n_pulse, 32'd0);

        // eight errors inside one window
        send(1'b1, 1'b0, 1'b1);
        k = 0;
        while (m_wpos != 0 && k < 300) begin send(1'b1, 1'b0, 1'b0); k++; end
        for (int e = 0; e < 8; e++) begin
            if (e != 0) for (int i = 0; i < 9; i++) send(1'b1, 1'b0, 1'b0);
            send(1'b1, 1'b1, 1'b0);
            if (e == 6) check("unlock_pre", {31'd0, locked}, 32'd1);
        end
        check("unlock_locked", {31'd0, locked}, 32'd0);
`ifdef PRBS31_CHK_ERRCNT_EN
        check("unlock_count", {16'd0, err_count}, 32'd8);
`else
        check("unlock_count", {16'd0, err_count}, 32'd0);
`endif
        wait_lock("relock");

        // random valid gaps, sparse errors and clears
        for (int i = 0; i < 3000; i++)
            send(($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 99) == 0));

        // constant zero line
        restart();
        lk = 0;
        for (int i = 0; i < 2000; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (locked === 1'b1) lk++;
        end
        check("zero_locked_cycles", lk, 32'd0);
        check("zero_err_count", {16'd0, err_count}, 32'd0);

        // valid toggling 1/0
        restart();
        nv = 0; got = 1'b0; n_pulse = 0;
        for (int i = 0; i < 800 && !got; i++) begin
            send((i % 2) == 0, 1'b0, 1'b0);
            if ((i % 2) == 0) nv++;
            if (locked === 1'b1) got = 1'b1;
        end
        check("toggle_lock", {31'd0, got}, 32'd1);
        check("toggle_latency", nv, 32'd95);
        check("toggle_pulses", n_pulse, 32'd0);

        // clear colliding with an error
        restart();
        wait_lock("lock3");
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b1);
        check("clr_err_pulse", {31'd0, err_pulse}, 32'd1);
        check("clr_err_count", {16'd0, err_count}, 32'd0);
        send(1'b1, 1'b1, 1'b0);
        check("pre_rst_locked", {31'd0, locked}, 32'd1);

        // asynchronous reset pulse mid-LOCKED
        #2;
        rst_n = 1'b1;
        model_reset();
        #1;
        check("arst_locked", {31'd0, locked}, 32'd0);
        check("arst_err_pulse", {31'd0, err_pulse}, 32'd0);
        check("arst_err_count", {16'd0, err_count}, 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        g = 31'd1;
        wait_lock("lock4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs31_checker.md
# prbs31_checker

Self-synchronising PRBS31 receiver/checker (x^31 + x^28 + 1) for the PRBS31 test-pattern generator. It sits at the far end of the serial link, fed with the generator's output bit, and seeds itself from the incoming stream. Once locked it predicts every following bit and counts mismatches, so a loopback or board-level link can be qualified on silicon.

## Interface

Parameters:
- `LOCK_CNT`, 64: consecutive correct predictions needed to enter LOCKED (1..255).
- `UNLOCK_ERRS`, 8: errors within one window that force loss of lock (1..255).
- `WINDOW`, 256: window length in valid bits for the unlock rule (power of two, 2..65536).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-high.
- `rx_bit`  in  1  received serial bit.
- `rx_valid`  in  1  `rx_bit` is sampled on this cycle; all state advances only on valid cycles.
- `clear`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  checker in LOCKED state.
- `err_pulse`  out  1  one-cycle pulse: the previous valid bit mismatched while LOCKED.
- `err_count`  out  16  saturating count of mismatches seen while LOCKED.

## Operation

- Shift register `s[30:0]` holds received history; `s[0]` is the newest bit. Prediction `p = s[27] ^ s[30]`.
- State SEED:
  - On each valid bit: shift `rx_bit` into `s[0]` and increment `seed_cnt`.
  - After the 31st valid bit (`seed_cnt` reaching 30), go to VERIFY, unless `s` (including the new bit) is all-zero. In that case stay in SEED and restart `seed_cnt`.
- State VERIFY:
  - On each valid bit: shift `rx_bit` into `s`.
  - `rx_bit == p`: increment `match_cnt`. At `LOCK_CNT` matches, go to LOCKED.
  - Mismatch: go to SEED with `seed_cnt` and `match_cnt` at 0.
- State LOCKED:
  - On each valid bit, shift `p` (not `rx_bit`) into `s`. A single flipped line bit therefore produces exactly one error.
  - Mismatch: `err_pulse` pulses, `err_count` increments, window error counter increments.
  - `win_cnt` counts valid bits and wraps at `WINDOW`. On wrap, the window error counter resets to 0.
  - When the window error counter reaches `UNLOCK_ERRS`: go to SEED; clear `seed_cnt`, `match_cnt` and window counters; `locked` deasserts.
- `err_count`:
  - Saturates at 0xFFFF.
  - `clear` has priority over a simultaneous error increment (result 0).
  - Counting continues across relock.
- Errors in SEED/VERIFY are not counted and do not pulse `err_pulse`.

## Timing

- All outputs are registered.
- Reset values: `locked=0`, `err_pulse=0`, `err_count=0`, state SEED, `s=0`, all counters 0.
- `err_pulse` is high for the single cycle after the erroneous valid bit's cycle. `err_count` updates on the same edge.
- `locked` rises the cycle after the valid bit that completes `LOCK_CNT` matches. With no gaps and a clean stream, that is `31 + LOCK_CNT` valid bits after reset.
- `locked` falls the cycle after the valid bit that hits `UNLOCK_ERRS`.
- `rx_valid` low: no state change; `err_pulse` is 0.
- Reset asserted at any time returns everything to reset values immediately; `err_count` is lost.

## Configuration

- `PRBS31_CHK_ERRCNT_EN` defined: the 16-bit saturating `err_count` and `clear` logic are compiled in.
- `PRBS31_CHK_ERRCNT_EN` not defined:
  - `err_count` is tied to 16'h0000 and `clear` is ignored.
  - `locked`, `err_pulse` and the unlock window logic are unchanged.

## Structure

- Shared package `prbs31_pkg`:
  - Tap constants `PRBS31_TAP_A=27`, `PRBS31_TAP_B=30`.
  - Width constant `PRBS31_W=31`.
  - State enum {SEED, VERIFY, LOCKED}.
  - Next-bit function `prbs31_next(s)`, so the generator and checker share the polynomial.
- One sub-module: `prbs31_win_mon`, which owns the window bit counter, the window error counter and the unlock decision. The FSM, shift register and `err_count` live in `prbs31_checker`.

## Test plan

- Generator stream seeded `31'd1`, `rx_valid=1` continuously:
  - `locked` rises the cycle after valid bit 95.
  - Zero `err_pulse` over the following 10000 bits.
- After lock, invert exactly one bit:
  - One `err_pulse`; `err_count=1`; `locked` stays 1.
  - Next 1000 bits produce no further errors.
- After lock, invert 8 bits within one 256-bit window:
  - `locked=0` the cycle after the 8th error; `err_count=8`.
  - With a clean stream, relock 95 valid bits later.
- Constant `rx_bit=0` for 2000 valid bits: `locked` never rises; `err_count=0`.
- Clean stream with `rx_valid` toggling 1/0: lock after 95 valid bits (190 cycles); no errors.
- Edge cases after lock:
  - `clear` on the same cycle as an error: `err_count=0`.
  - `rst_n` pulse mid-LOCKED: all outputs return to 0 asynchronously.
